// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               fq_entry_t is one fetch-queue slot: the fetch PC, the returned
//               instruction word and a flag telling whether the word arrived.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    localparam int XLEN            = 32;
    localparam int INSN_W          = 32;
    localparam int IMEM_WORD_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INSN_W-1:0] insn;
        logic              filled;
    } fq_entry_t;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_queue
// Description : Ring of fetch-queue entries. An entry is allocated when a fetch
//               is accepted, filled in order when its response returns, and
//               popped from the head once filled. Flush empties the ring.
// Ports       : clk, rst          clock, synchronous active-high reset
//               i_flush           drop every entry (wins over all other ops)
//               i_alloc/_pc       allocate tail entry with the fetch PC
//               i_fill/_insn      fill the oldest unfilled entry
//               i_pop             retire the head entry
//               o_head_valid      head exists and was filled in an earlier cycle
//               o_head_pc/_insn   head entry contents
//               o_occupancy       allocated entries
//               o_unfilled        allocated entries still awaiting a response
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter  int FQ_DEPTH = 2,
    localparam int c_cnt_w  = $clog2(FQ_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    input  logic                i_alloc,
    input  logic [XLEN-1:0]     i_alloc_pc,
    input  logic                i_fill,
    input  logic [INSN_W-1:0]   i_fill_insn,
    input  logic                i_pop,
    output logic                o_head_valid,
    output logic [XLEN-1:0]     o_head_pc,
    output logic [INSN_W-1:0]   o_head_insn,
    output logic [c_cnt_w-1:0]  o_occupancy,
    output logic [c_cnt_w-1:0]  o_unfilled
);

    localparam int c_ptr_w = $clog2(FQ_DEPTH);

    fq_entry_t             r_ring [FQ_DEPTH];
    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic [c_ptr_w-1:0]    r_fill_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_cnt_w-1:0]    r_unfilled;
    logic                  w_wr_en;

    assign w_wr_en = !rst && !i_flush;

    // Pointers are exactly log2(depth) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill_ptr <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
        end else begin
            if (i_alloc) r_tail     <= r_tail + 1'b1;
            if (i_fill)  r_fill_ptr <= r_fill_ptr + 1'b1;
            if (i_pop)   r_head     <= r_head + 1'b1;
            r_count    <= r_count + c_cnt_w'(i_alloc) - c_cnt_w'(i_pop);
            r_unfilled <= r_unfilled + c_cnt_w'(i_alloc) - c_cnt_w'(i_fill);
        end
    end

    // Storage has no reset: stale slots are masked by r_count.
    always_ff @(posedge clk) begin
        if (w_wr_en && i_alloc) begin
            r_ring[r_tail] <= '{pc: i_alloc_pc, insn: '0, filled: 1'b0};
        end
        if (w_wr_en && i_fill) begin
            r_ring[r_fill_ptr].insn   <= i_fill_insn;
            r_ring[r_fill_ptr].filled <= 1'b1;
        end
    end

    assign o_head_valid = (r_count != '0) && r_ring[r_head].filled;
    assign o_head_pc    = r_ring[r_head].pc;
    assign o_head_insn  = r_ring[r_head].insn;
    assign o_occupancy  = r_count;
    assign o_unfilled   = r_unfilled;

endmodule : ifu_fetch_queue
`default_nettype wire

// File: rtl/ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pc_gen
// Description : Fetch-stage PC generator. Issues in-order word fetches on the
//               imem bus, buffers responses with their PCs for decode, and
//               drops wrong-path responses still in flight after a redirect.
// Ports       : clk, rst                    clock, synchronous active-high reset
//               redirect_valid/redirect_pc  taken branch target
//               imem_req/imem_addr          fetch request (word aligned)
//               imem_ready                  request accepted this cycle
//               imem_rvalid/imem_rdata      in-order response word
//               if_valid/if_pc/if_insn      instruction to decode
//               if_ready                    decode accepts head
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              FQ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [INSN_W-1:0]   imem_rdata,
    output logic                if_valid,
    output logic [XLEN-1:0]     if_pc,
    output logic [INSN_W-1:0]   if_insn,
    input  logic                if_ready
);

    localparam int              c_cnt_w     = $clog2(FQ_DEPTH) + 1;
    localparam logic [XLEN-1:0] c_word_mask = ~XLEN'(IMEM_WORD_BYTES - 1);

    logic [XLEN-1:0]    r_pc;
    logic [c_cnt_w-1:0] r_kill_cnt;

    logic [c_cnt_w-1:0] w_occupancy;
    logic [c_cnt_w-1:0] w_unfilled;
    logic [c_cnt_w:0]   w_inflight;
    logic               w_head_valid;
    logic               w_accept;
    logic               w_kill_active;
    logic               w_fill;
    logic               w_pop;

    // Dead responses still owed by the bus occupy slots just like live
    // entries, so the issue limit counts both.
    assign w_inflight    = {1'b0, w_occupancy} + {1'b0, r_kill_cnt};
    assign imem_req      = !rst && !redirect_valid
                         && (w_inflight < (c_cnt_w + 1)'(FQ_DEPTH));
    assign imem_addr     = r_pc;
    assign w_accept      = imem_req && imem_ready;
    assign w_kill_active = (r_kill_cnt != '0);
    assign w_fill        = imem_rvalid && !w_kill_active;
    assign if_valid      = !rst && !redirect_valid && w_head_valid;
    assign w_pop         = if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC & c_word_mask;
            r_kill_cnt <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc & c_word_mask;
            // A same-cycle response either fills an unfilled entry (one fewer
            // to kill) or retires one kill; both reduce the total by one.
            r_kill_cnt <= r_kill_cnt + w_unfilled - c_cnt_w'(imem_rvalid);
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + XLEN'(IMEM_WORD_BYTES);
            end
            if (imem_rvalid && w_kill_active) begin
                r_kill_cnt <= r_kill_cnt - 1'b1;
            end
        end
    end

    ifu_fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (redirect_valid),
        .i_alloc      (w_accept),
        .i_alloc_pc   (r_pc),
        .i_fill       (w_fill),
        .i_fill_insn  (imem_rdata),
        .i_pop        (w_pop),
        .o_head_valid (w_head_valid),
        .o_head_pc    (if_pc),
        .o_head_insn  (if_insn),
        .o_occupancy  (w_occupancy),
        .o_unfilled   (w_unfilled)
    );

endmodule : ifu_pc_gen
`default_nettype wire
